// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and the burst-length decode.
package ahb_pkg;

  localparam int unsigned BEAT_W = 4;
  localparam int unsigned LEN_W  = 5;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Beat count of a fixed-length burst; 0 for SINGLE and undefined INCR.
  function automatic logic [LEN_W-1:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = LEN_W'(4);
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = LEN_W'(8);
      HBURST_WRAP16, HBURST_INCR16: burst_len = LEN_W'(16);
      default:                      burst_len = '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the bus masters, the muxed bus and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  localparam int unsigned MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic                   hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic [MW-1:0]          hmaster_data;
  logic                   hmastlock;

  // Requesters and the muxed bus drive this side.
  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmaster_data, hmastlock
  );

  // The arbiter consumes requests and bus status and drives the selects.
  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmaster_data, hmastlock
  );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin selector: first requester at or after start, wrapping.
module ahb_rr_picker #(
  parameter int unsigned NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] start,
  input  logic [$clog2(NUM_MASTERS)-1:0] dflt,
  output logic [$clog2(NUM_MASTERS)-1:0] winner
);
  localparam int unsigned MW = $clog2(NUM_MASTERS);

  logic          found;
  logic [MW-1:0] idx;

  always_comb begin
    winner = dflt;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = MW'((32'(start) + i) % NUM_MASTERS);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter: round-robin grant with fixed-burst and locked-sequence protection.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic               hclk,
  input  logic               hreset,
  ahb_bus_arbiter_if.slave   bus
);
  localparam int unsigned   MW       = $clog2(NUM_MASTERS);
  localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0] LAST_IDX = MW'(NUM_MASTERS - 1);

  arb_state_t             state, state_nxt;
  logic [BEAT_W-1:0]      beats, beats_nxt;
  logic                   rearb;
  arb_state_t             arb_state;
  logic [BEAT_W-1:0]      arb_beats;
  logic                   arb_rearb;
  htrans_t                trans;
  logic [LEN_W-1:0]       len;
  logic                   own_lock;
  logic                   own_req;
  logic [MW-1:0]          start_idx;
  logic [MW-1:0]          winner;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [MW-1:0]          master_nxt;
  logic [MW-1:0]          master_data_nxt;
  logic                   mastlock_nxt;

  assign trans     = htrans_t'(bus.htrans);
  assign len       = burst_len(bus.hburst);
  assign own_lock  = bus.hlock[bus.hmaster];
  assign own_req   = bus.hbusreq[bus.hmaster];
  assign start_idx = (bus.hmaster == LAST_IDX) ? '0 : bus.hmaster + MW'(1);

  ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (bus.hbusreq),
    .start  (start_idx),
    .dflt   (DEF_IDX),
    .winner (winner)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state            <= ST_ARB;
      beats            <= '0;
      bus.hgrant       <= NUM_MASTERS'(1) << DEF_IDX;
      bus.hmaster      <= DEF_IDX;
      bus.hmaster_data <= DEF_IDX;
      bus.hmastlock    <= 1'b0;
    end else begin
      state            <= state_nxt;
      beats            <= beats_nxt;
      bus.hgrant       <= grant_nxt;
      bus.hmaster      <= master_nxt;
      bus.hmaster_data <= master_data_nxt;
      bus.hmastlock    <= mastlock_nxt;
    end
  end

  // Next state; arb_* is the outcome of the idle-bus rules, reused on early burst end.
  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    rearb     = 1'b0;
    arb_state = ST_ARB;
    arb_beats = beats;
    arb_rearb = 1'b0;

    if (trans == HTRANS_NONSEQ && len != '0) begin
      arb_state = ST_BURST;
      arb_beats = BEAT_W'(len - LEN_W'(1));
    end else if (own_lock) begin
      arb_state = ST_LOCKED;
    end else if (!(own_req && (trans == HTRANS_SEQ || trans == HTRANS_BUSY))) begin
      arb_rearb = 1'b1;
    end

    case (state)
      ST_ARB: begin
        if (bus.hready) begin
          state_nxt = arb_state;
          beats_nxt = arb_beats;
          rearb     = arb_rearb;
        end
      end
      ST_BURST: begin
        if (!bus.hready) begin
          if (bus.hresp) begin
            state_nxt = ST_ARB;
            beats_nxt = '0;
          end
        end else begin
          case (trans)
            HTRANS_SEQ: begin
              beats_nxt = beats - BEAT_W'(1);
              if (beats == BEAT_W'(1)) begin
                // A locked burst rolls straight into the locked sequence.
                if (own_lock) begin
                  state_nxt = ST_LOCKED;
                end else begin
                  state_nxt = ST_ARB;
                  rearb     = 1'b1;
                end
              end
            end
            HTRANS_BUSY: ;
            default: begin
              state_nxt = arb_state;
              beats_nxt = arb_beats;
              rearb     = arb_rearb;
            end
          endcase
        end
      end
      ST_LOCKED: begin
        if (bus.hready && !own_lock) begin
          state_nxt = ST_ARB;
          rearb     = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        beats_nxt = '0;
      end
    endcase
  end

  // Next values of the registered selects; only accepted edges move them.
  always_comb begin
    grant_nxt       = bus.hgrant;
    master_nxt      = bus.hmaster;
    master_data_nxt = bus.hmaster_data;
    mastlock_nxt    = bus.hmastlock;
    if (bus.hready) begin
      master_data_nxt = bus.hmaster;
      if (rearb) begin
        master_nxt   = winner;
        grant_nxt    = NUM_MASTERS'(1) << winner;
        mastlock_nxt = bus.hlock[winner];
      end
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scoreboard bench for ahb_bus_arbiter (4 masters, default master 0).
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int unsigned N = 4;
  localparam logic [1:0] TI = 2'd0, TB = 2'd1, TN = 2'd2, TS = 2'd3;
  localparam logic [2:0] BSG = 3'd0, BIN = 3'd1, B4 = 3'd3, B8 = 3'd5;

  logic hclk = 1'b0;
  logic hreset;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    int         id;
    logic [1:0] m;
    logic [1:0] md;
    logic       lk;
  } exp_t;

  exp_t expq[$];
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   step_id = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  function automatic void check(input string nm, input int id,
                                input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, req);
    end
  endfunction

  // Drive one cycle of inputs; optionally queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                      input logic rsp, input logic chk, input logic [1:0] em,
                      input logic [1:0] emd, input logic eml);
    exp_t e;
    hreset      = rst;
    bus.hbusreq = req;
    bus.hlock   = lck;
    bus.htrans  = tr;
    bus.hburst  = bu;
    bus.hready  = rdy;
    bus.hresp   = rsp;
    step_id++;
    if (chk) begin
      e = '{cyc: cyc + 1, id: step_id, m: em, md: emd, lk: eml};
      expq.push_back(e);
    end
    @(posedge hclk);
    #1;
  endtask

  // Monitor: pops every expectation due by this cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        e = expq.pop_front();
        check("sample_cycle", e.id, 32'(e.cyc), 32'(cyc));
        check("hgrant", e.id, 32'(bus.hgrant), 32'(1) << e.m);
        check("hmaster", e.id, 32'(bus.hmaster), 32'(e.m));
        check("hmaster_data", e.id, 32'(bus.hmaster_data), 32'(e.md));
        check("hmastlock", e.id, 32'(bus.hmastlock), 32'(e.lk));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    hreset      = 1'b1;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = TI;
    bus.hburst  = BSG;
    bus.hready  = 1'b1;
    bus.hresp   = 1'b0;

    // reset held two cycles
    step(1, 4'b0000, 4'b0000, TI, BSG, 1, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, TI, BSG, 1, 0, 1, 0, 0, 0);

    // round robin between masters 1 and 2 with SINGLE transfers
    step(0, 4'b0110, 4'b0000, TN, BSG, 1, 0, 1, 1, 0, 0);
    step(0, 4'b0110, 4'b0000, TN, BSG, 1, 0, 1, 2, 1, 0);
    step(0, 4'b0110, 4'b0000, TN, BSG, 1, 0, 1, 1, 2, 0);
    step(0, 4'b0110, 4'b0000, TN, BSG, 1, 0, 1, 2, 1, 0);

    // INCR4 by master 1 while master 2 waits
    step(0, 4'b0010, 4'b0000, TI, BSG, 1, 0, 1, 1, 2, 0);
    step(0, 4'b0110, 4'b0000, TN, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 2, 1, 0);

    // INCR4 with three wait states on beat 2
    step(0, 4'b0010, 4'b0000, TI, BSG, 1, 0, 1, 1, 2, 0);
    step(0, 4'b0110, 4'b0000, TN, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  0, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  0, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  0, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 1, 1, 0);
    step(0, 4'b0110, 4'b0000, TS, B4,  1, 0, 1, 2, 1, 0);

    // master 3 locked for five cycles against masters 0 and 1
    step(0, 4'b1011, 4'b1000, TI, BSG, 1, 0, 1, 3, 2, 1);
    step(0, 4'b1011, 4'b1000, TN, BSG, 1, 0, 1, 3, 3, 1);
    step(0, 4'b1011, 4'b1000, TN, BSG, 1, 0, 1, 3, 3, 1);
    step(0, 4'b1011, 4'b1000, TN, BSG, 1, 0, 1, 3, 3, 1);
    step(0, 4'b1011, 4'b1000, TN, BSG, 1, 0, 1, 3, 3, 1);
    step(0, 4'b1011, 4'b0000, TI, BSG, 1, 0, 1, 0, 3, 0);

    // INCR8 by master 2 cut by an ERROR response, then nobody requests
    step(0, 4'b0100, 4'b0000, TI, BSG, 1, 0, 1, 2, 0, 0);
    step(0, 4'b0100, 4'b0000, TN, B8,  1, 0, 1, 2, 2, 0);
    step(0, 4'b0100, 4'b0000, TS, B8,  1, 0, 1, 2, 2, 0);
    step(0, 4'b0100, 4'b0000, TS, B8,  0, 1, 1, 2, 2, 0);
    step(0, 4'b0000, 4'b0000, TS, B8,  1, 1, 1, 0, 2, 0);
    step(0, 4'b0000, 4'b0000, TI, BSG, 1, 0, 1, 0, 0, 0);

    // early termination of INCR4 by IDLE
    step(0, 4'b0001, 4'b0000, TN, B4,  1, 0, 1, 0, 0, 0);
    step(0, 4'b0001, 4'b0000, TS, B4,  1, 0, 1, 0, 0, 0);
    step(0, 4'b0010, 4'b0000, TI, B4,  1, 0, 1, 1, 0, 0);

    // undefined INCR: owner keeps the bus through SEQ/BUSY
    step(0, 4'b0011, 4'b0000, TS, BIN, 1, 0, 1, 1, 1, 0);
    step(0, 4'b0011, 4'b0000, TB, BIN, 1, 0, 1, 1, 1, 0);
    step(0, 4'b0011, 4'b0000, TI, BIN, 1, 0, 1, 0, 1, 0);

    // reset in the middle of a locked sequence
    step(0, 4'b1000, 4'b1000, TI, BSG, 1, 0, 1, 3, 0, 1);
    step(0, 4'b1000, 4'b1000, TI, BSG, 1, 0, 1, 3, 3, 1);
    step(1, 4'b1000, 4'b1000, TI, BSG, 1, 0, 1, 0, 0, 0);
    step(0, 4'b1000, 4'b1000, TI, BSG, 1, 0, 1, 3, 0, 1);

    // locked INCR4 by master 3 flows into LOCKED, then hands over to master 0
    step(0, 4'b1001, 4'b1000, TN, B4,  1, 0, 1, 3, 3, 1);
    step(0, 4'b1001, 4'b1000, TS, B4,  1, 0, 1, 3, 3, 1);
    step(0, 4'b1001, 4'b1000, TS, B4,  1, 0, 1, 3, 3, 1);
    step(0, 4'b1001, 4'b1000, TS, B4,  1, 0, 1, 3, 3, 1);
    step(0, 4'b1001, 4'b0000, TI, BSG, 1, 0, 1, 0, 3, 0);

    repeat (3) @(negedge hclk);
    #1;
    check("queue_drained", 0, 32'(expq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
